serial_add_ctrl: RTL and testbench
==================================

// Module: serial_add_ctrl
// PURPOSE
//   Bit-serial adder controller: time-multiplexes one 1-bit full adder (a+b+x -> {carry,sum})
//   over WIDTH cycles to add two WIDTH-bit operands, LSB first.
//   Sits between the CPU control path and the shared 1-bit adder resource.
//   Provides start/busy/done handshake, result and carry-out registers.
// PARAMETERS
//   WIDTH   8   operand/result width in bits; legal range 1..32
// PORTS
//   i_clk    in   1      clock, rising edge
//   i_rst_n  in   1      asynchronous active-low reset
//   i_start  in   1      start request; sampled on i_clk rise
//   i_a      in   WIDTH  operand A; captured with accepted start
//   i_b      in   WIDTH  operand B; captured with accepted start
//   i_sub    in   1      subtract select; captured with start (see CONFIGURATION)
//   o_busy   out  1      1 while in RUN
//   o_done   out  1      1-cycle pulse: result valid
//   o_sum    out  WIDTH  result; held until next accepted start
//   o_cout   out  1      final carry out of MSB; held with o_sum
// BEHAVIOUR
//   Reset (async, i_rst_n=0): state=IDLE; o_busy=0, o_done=0, o_sum=0, o_cout=0;
//     shift regs, carry FF, bit counter = 0. Takes effect immediately, even mid-RUN;
//     partial result discarded; no o_done for the aborted operation.
//   FSM states: IDLE, RUN, DONE.
//     IDLE: i_start=1 -> RUN; load A_sr=i_a, B_sr=i_b, carry=0, cnt=0.
//     RUN: per cycle: {c,s} = A_sr[0] + B_sr[0] + carry (2-bit, no truncation);
//       carry<=c; result_sr <= {s, result_sr[WIDTH-1:1]}; A_sr,B_sr shift right; cnt++.
//       After WIDTH RUN cycles (cnt==WIDTH-1 on last) -> DONE; o_sum<=final result_sr, o_cout<=c.
//     DONE: o_done=1 for exactly this one cycle. i_start=1 -> RUN (back-to-back, reload);
//       else -> IDLE.
//   Latency: start accepted at edge k -> o_busy=1 from k through k+WIDTH; o_done=1
//     between edges k+WIDTH and k+WIDTH+1. Throughput: one op per WIDTH+1 cycles.
//   i_start while RUN: ignored, no queuing; operands unchanged.
//   o_sum/o_cout updated only on RUN->DONE; stable in IDLE and during a later RUN.
//   Wrap-around: result is modulo 2^WIDTH; overflow reported only via o_cout.
//   WIDTH=1: RUN lasts one cycle; counter width = max(1,$clog2(WIDTH)).
// CONFIGURATION
//   SERIAL_ADD_SUB_EN defined: i_sub captured at start; if 1, B_sr loaded with ~i_b and
//     carry initialised to 1 (A-B two's complement); o_cout=1 means no borrow.
//   SERIAL_ADD_SUB_EN undefined: i_sub ignored (port kept, unused); always A+B, carry init 0.
// TESTING
//   1. WIDTH=8: A=0x35,B=0x4A,start 1 cycle -> o_busy 8 cycles, o_done pulse at edge k+8,
//      o_sum=0x7F, o_cout=0.
//   2. A=0xFF,B=0x01 -> o_sum=0x00, o_cout=1; o_sum then holds 0x00 in IDLE for 20 cycles.
//   3. Start A=0x12,B=0x34; pulse i_start with A=0xFF,B=0xFF at RUN cycle 3 -> ignored,
//      o_sum=0x46, single o_done pulse.
//   4. Start, drop i_rst_n at RUN cycle 4 (between edges) -> all outputs 0 immediately,
//      no o_done; after release, A=0x01,B=0x02 -> o_sum=0x03.
//   5. i_start held high through DONE: A=0x0F,B=0x01 then A=0x80,B=0x80 -> o_sum=0x10 cout0,
//      next RUN starts with no idle cycle, o_sum=0x00 cout1, o_done pulses 9 cycles apart.
//   6. WIDTH=1: all 8 {a,b} x carry-init combos -> {o_cout,o_sum} = a+b+x truth table;
//      with SERIAL_ADD_SUB_EN, WIDTH=8, i_sub=1: 0x10-0x01 -> 0x0F cout1; 0x00-0x01 -> 0xFF cout0.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one 1-bit full adder reused over WIDTH cycles, LSB first.
// Optional subtract mode enabled by defining SERIAL_ADD_SUB_EN.
module serial_add_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_sub,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [WIDTH-1:0] res_next;
    logic [WIDTH-1:0] b_load;
    logic             carry;
    logic             carry_init;
    logic [CW-1:0]    cnt;
    logic [1:0]       bit_sum;

`ifdef SERIAL_ADD_SUB_EN
    // A-B as A + ~B + 1
    assign b_load     = i_sub ? ~i_b : i_b;
    assign carry_init = i_sub;
`else
    logic unused_sub;
    assign unused_sub = i_sub;
    assign b_load     = i_b;
    assign carry_init = 1'b0;
`endif

    // Shared full adder and the result shifted in from the MSB side
    always_comb begin
        bit_sum = {1'b0, a_sr[0]} + {1'b0, b_sr[0]} + {1'b0, carry};
        res_next = res_sr >> 1;
        res_next[WIDTH-1] = bit_sum[0];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            o_busy <= 1'b0;
            o_done <= 1'b0;
            o_sum  <= '0;
            o_cout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    o_done <= 1'b0;
                    if (i_start) begin
                        a_sr   <= i_a;
                        b_sr   <= b_load;
                        carry  <= carry_init;
                        cnt    <= '0;
                        o_busy <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    carry  <= bit_sum[1];
                    res_sr <= res_next;
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    cnt    <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        o_sum  <= res_next;
                        o_cout <= bit_sum[1];
                        o_busy <= 1'b0;
                        o_done <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    o_done <= 1'b0;
                    // Back-to-back start reloads without an idle cycle
                    if (i_start) begin
                        a_sr   <= i_a;
                        b_sr   <= b_load;
                        carry  <= carry_init;
                        cnt    <= '0;
                        o_busy <= 1'b1;
                        state  <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    o_busy <= 1'b0;
                    o_done <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl: WIDTH=8 instance plus a WIDTH=1 instance.
// Subtract vectors are exercised when SERIAL_ADD_SUB_EN is defined.
module tb_serial_add_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] op_a = '0;
    logic [7:0] op_b = '0;
    logic       op_sub = 1'b0;
    logic       busy, done, cout;
    logic [7:0] sum;

    logic       start1 = 1'b0;
    logic [0:0] a1 = '0;
    logic [0:0] b1 = '0;
    logic       sub1 = 1'b0;
    logic       busy1, done1, cout1;
    logic [0:0] sum1;

    int nvec = 0;
    int nmis = 0;

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(8)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_a(op_a), .i_b(op_b),
        .i_sub(op_sub), .o_busy(busy), .o_done(done), .o_sum(sum), .o_cout(cout)
    );

    serial_add_ctrl #(.WIDTH(1)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start1), .i_a(a1), .i_b(b1),
        .i_sub(sub1), .o_busy(busy1), .o_done(done1), .o_sum(sum1), .o_cout(cout1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full operation on the 8-bit instance with latency and busy-length checks
    task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic sub, input logic [7:0] es, input logic ec);
        int n;
        int nb;
        op_a = a; op_b = b; op_sub = sub; start = 1'b1;
        tick();
        start = 1'b0;
        nb = busy ? 1 : 0;
        n = 0;
        while (!done && n < 20) begin
            tick();
            n++;
            if (busy) nb++;
        end
        chk({tag, "_lat"}, n, 8);
        chk({tag, "_busy"}, nb, 8);
        chk({tag, "_sum"}, {24'd0, sum}, {24'd0, es});
        chk({tag, "_cout"}, {31'd0, cout}, {31'd0, ec});
        tick();
        chk({tag, "_pulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int n;
        int n2;
        int ndone;
        logic stable;
        logic [1:0] exp1;

        #12;
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_sum", {24'd0, sum}, 0);
        chk("rst_cout", {31'd0, cout}, 0);
        rst_n = 1'b1;
        tick();

        do_op("t1", 8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0);
        do_op("t2", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (sum !== 8'h00 || cout !== 1'b1 || done !== 1'b0) stable = 1'b0;
        end
        chk("t2_hold", {31'd0, stable}, 1);
        do_op("wrap", 8'hC8, 8'h64, 1'b0, 8'h2C, 1'b1);
        do_op("alt", 8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0);

        // Start during RUN is ignored
        op_a = 8'h12; op_b = 8'h34; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        op_a = 8'hFF; op_b = 8'hFF; start = 1'b1;
        tick();
        start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                ndone++;
                chk("t3_sum", {24'd0, sum}, 32'h46);
            end
            tick();
        end
        chk("t3_ndone", ndone, 1);

        // Async reset mid-RUN
        op_a = 8'h55; op_b = 8'h11; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        chk("t4_busy", {31'd0, busy}, 0);
        chk("t4_done", {31'd0, done}, 0);
        chk("t4_sum", {24'd0, sum}, 0);
        chk("t4_cout", {31'd0, cout}, 0);
        tick();
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) ndone++;
        end
        chk("t4_nodone", ndone, 0);
        do_op("t4", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0);

        // Start held high through DONE: back-to-back operations
        op_a = 8'h0F; op_b = 8'h01; op_sub = 1'b0; start = 1'b1;
        tick();
        op_a = 8'h80; op_b = 8'h80;
        n = 0;
        while (!done && n < 20) begin tick(); n++; end
        chk("t5a_lat", n, 8);
        chk("t5a_sum", {24'd0, sum}, 32'h10);
        chk("t5a_cout", {31'd0, cout}, 0);
        tick();
        chk("t5_nogap", {31'd0, busy}, 1);
        start = 1'b0;
        n2 = 1;
        while (!done && n2 < 30) begin tick(); n2++; end
        chk("t5_gap", n2, 9);
        chk("t5b_sum", {24'd0, sum}, 32'h00);
        chk("t5b_cout", {31'd0, cout}, 1);
        tick();

`ifdef SERIAL_ADD_SUB_EN
        do_op("sub1", 8'h10, 8'h01, 1'b1, 8'h0F, 1'b1);
        do_op("sub2", 8'h00, 8'h01, 1'b1, 8'hFF, 1'b0);
`else
        do_op("subign", 8'h10, 8'h01, 1'b1, 8'h11, 1'b0);
`endif

        // WIDTH=1 full-adder truth table
        for (int x = 0; x < 2; x++) begin
`ifndef SERIAL_ADD_SUB_EN
            if (x == 1) break;
`endif
            for (int v = 0; v < 4; v++) begin
                a1 = 1'(v >> 1);
                b1 = (x == 1) ? ~1'(v) : 1'(v);
                sub1 = 1'(x);
                start1 = 1'b1;
                tick();
                start1 = 1'b0;
                n = 0;
                while (!done1 && n < 10) begin tick(); n++; end
                exp1 = 2'(v >> 1) + 2'(v & 1) + 2'(x);
                chk("w1_lat", n, 1);
                chk("w1_res", {30'd0, cout1, sum1}, {30'd0, exp1});
                tick();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
